// File: rtl/hazard_stall_controller_if.sv
// Bundle of hazard-detection inputs and pipeline-control outputs shared
// between the 5-stage pipeline datapath (master) and the stall controller (slave).
`timescale 1ns/1ps
interface hazard_stall_controller_if #(
    parameter int CNT_W = 16
);
    // Pipeline state presented to the controller
    logic [4:0]       IF_ID_Rs;
    logic [4:0]       IF_ID_Rt;
    logic             ID_Branch;
    logic             ID_BranchTaken;
    logic             ID_Jump;
    logic             ID_EX_MemRead;
    logic             ID_EX_RegWrite;
    logic [4:0]       ID_EX_Rd;
    logic             EX_MEM_MemRead;
    logic             EX_MEM_MemWrite;
    logic [4:0]       EX_MEM_Rd;
    logic             mem_ready;

    // Sequencing controls returned to the pipeline
    logic             PCWrite;
    logic             IF_ID_Write;
    logic             IF_ID_Flush;
    logic             ID_EX_Write;
    logic             ID_EX_Flush;
    logic             EX_MEM_Write;
    logic             MEM_WB_Flush;
    logic [CNT_W-1:0] stall_cycles;
    logic             mem_error;

    // Datapath side
    modport master (
        output IF_ID_Rs, IF_ID_Rt, ID_Branch, ID_BranchTaken, ID_Jump,
               ID_EX_MemRead, ID_EX_RegWrite, ID_EX_Rd,
               EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_Rd, mem_ready,
        input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
               EX_MEM_Write, MEM_WB_Flush, stall_cycles, mem_error
    );

    // Controller side
    modport slave (
        input  IF_ID_Rs, IF_ID_Rt, ID_Branch, ID_BranchTaken, ID_Jump,
               ID_EX_MemRead, ID_EX_RegWrite, ID_EX_Rd,
               EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_Rd, mem_ready,
        output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
               EX_MEM_Write, MEM_WB_Flush, stall_cycles, mem_error
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller for the 5-stage MIPS core.
// Freezes the pipe during data-memory wait states, inserts bubbles for
// load-use and ID-stage branch operand hazards, flushes IF/ID on redirects,
// and tracks a saturating stall-cycle count plus a sticky memory timeout.
`timescale 1ns/1ps
module hazard_stall_controller #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    hazard_stall_controller_if.slave hs
);

    localparam int                WCNT_W   = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0]  SC_MAX   = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
    logic              mem_error_q, mem_error_d;

    logic mem_access, freeze;
    logic ex_hit, mem_hit, load_use, br_hazard, stall, redirect;

    logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
    logic ex_mem_write, mem_wb_flush;

    // Register 0 is hard-wired zero, so it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] producer, input logic [4:0] consumer);
        return (producer != 5'd0) && (producer == consumer);
    endfunction

    // Hazard classification from the current pipeline contents
    always_comb begin
        mem_access = hs.EX_MEM_MemRead | hs.EX_MEM_MemWrite;
        freeze     = mem_access & ~hs.mem_ready;
        ex_hit     = reg_match(hs.ID_EX_Rd, hs.IF_ID_Rs) | reg_match(hs.ID_EX_Rd, hs.IF_ID_Rt);
        mem_hit    = reg_match(hs.EX_MEM_Rd, hs.IF_ID_Rs) | reg_match(hs.EX_MEM_Rd, hs.IF_ID_Rt);
        load_use   = hs.ID_EX_MemRead & ex_hit;
        // A branch compares in ID, so even an ALU result in EX is too late to forward;
        // a load in MEM is likewise not yet available.
        br_hazard  = hs.ID_Branch & ((hs.ID_EX_RegWrite & ex_hit) | (hs.EX_MEM_MemRead & mem_hit));
        stall      = ~freeze & (load_use | br_hazard);
        // Branch outcome is only trusted once operands are settled (no stall).
        redirect   = ~freeze & ~stall & (hs.ID_Jump | (hs.ID_Branch & hs.ID_BranchTaken));
    end

    // Next-state, wait-counter and stall-counter logic
    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        mem_error_d    = mem_error_q;
        stall_cycles_d = stall_cycles_q;

        case (state_q)
            RUN: begin
                wait_cnt_d = '0;
                if (freeze) begin
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                wait_cnt_d = (wait_cnt_q == WCNT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
                if (wait_cnt_d == WCNT_MAX) begin
                    mem_error_d = 1'b1;
                end
                // Leave once the access completes (or disappears); a timeout never forces an exit.
                if (!freeze) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase

        if (!pc_write && (stall_cycles_q != SC_MAX)) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
    end

    // Pipeline enables/flushes; priority rst > freeze > stall > redirect
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_write = 1'b1;
        mem_wb_flush = 1'b0;

        if (rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (freeze) begin
            // Everything upstream of MEM holds; WB receives a bubble each wait cycle.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (stall) begin
            // Hold IF and ID, let EX/MEM drain, inject a bubble into EX.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_flush  = 1'b1;
        end else if (redirect) begin
            if_id_flush  = 1'b1;
        end
    end

    // State and counter registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= RUN;
            wait_cnt_q     <= '0;
            stall_cycles_q <= '0;
            mem_error_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            stall_cycles_q <= stall_cycles_d;
            mem_error_q    <= mem_error_d;
        end
    end

    assign hs.PCWrite      = pc_write;
    assign hs.IF_ID_Write  = if_id_write;
    assign hs.IF_ID_Flush  = if_id_flush;
    assign hs.ID_EX_Write  = id_ex_write;
    assign hs.ID_EX_Flush  = id_ex_flush;
    assign hs.EX_MEM_Write = ex_mem_write;
    assign hs.MEM_WB_Flush = mem_wb_flush;
    assign hs.stall_cycles = stall_cycles_q;
    assign hs.mem_error    = mem_error_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller: directed scenarios with
// literal expectations plus randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_hazard_stall_controller;

    localparam int CNT_W   = 3;
    localparam int TIMEOUT = 4;
    localparam int SC_MAX  = (1 << CNT_W) - 1;

    // Output pattern order: {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_MEM_Write, MEM_WB_Flush}
    localparam logic [6:0] P_RESET  = 7'b0010101;
    localparam logic [6:0] P_FREEZE = 7'b0000001;
    localparam logic [6:0] P_STALL  = 7'b0001110;
    localparam logic [6:0] P_REDIR  = 7'b1111010;
    localparam logic [6:0] P_RUN    = 7'b1101010;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc_n    = 0;

    // Behavioural model state
    bit m_wait = 0;
    int m_wcnt = 0;
    int m_stall = 0;
    bit m_err = 0;

    hazard_stall_controller_if #(.CNT_W(CNT_W)) bus ();

    hazard_stall_controller #(
        .CNT_W      (CNT_W),
        .MEM_TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hs (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] outv();
        return {bus.PCWrite, bus.IF_ID_Write, bus.IF_ID_Flush, bus.ID_EX_Write,
                bus.ID_EX_Flush, bus.EX_MEM_Write, bus.MEM_WB_Flush};
    endfunction

    function automatic bit hit(input logic [4:0] r);
        return (r != 5'd0) && ((r == bus.IF_ID_Rs) || (r == bus.IF_ID_Rt));
    endfunction

    // Per-cycle compare against the model, then advance the model across the next edge
    always @(negedge clk) begin
        logic [6:0] e;
        bit frz, lu, bh, rd;
        cyc_n++;
        if (rst) begin
            m_wait = 0; m_wcnt = 0; m_stall = 0; m_err = 0;
            e = P_RESET;
        end else begin
            frz = (bus.EX_MEM_MemRead || bus.EX_MEM_MemWrite) && !bus.mem_ready;
            lu  = bus.ID_EX_MemRead && hit(bus.ID_EX_Rd);
            bh  = bus.ID_Branch && ((bus.ID_EX_RegWrite && hit(bus.ID_EX_Rd)) ||
                                    (bus.EX_MEM_MemRead && hit(bus.EX_MEM_Rd)));
            rd  = bus.ID_Jump || (bus.ID_Branch && bus.ID_BranchTaken);
            if (frz)            e = P_FREEZE;
            else if (lu || bh)  e = P_STALL;
            else if (rd)        e = P_REDIR;
            else                e = P_RUN;
        end
        chk("model_outputs", 32'(outv()), 32'(e));
        chk("model_stall_cycles", 32'(bus.stall_cycles), 32'(m_stall));
        chk("model_mem_error", 32'(bus.mem_error), 32'(m_err));
        $display("cyc %0d rst=%0b out=%b sc=%0d err=%0b", cyc_n, rst, outv(), bus.stall_cycles, bus.mem_error);
        if (!rst) begin
            if (e[6] == 1'b0) m_stall = (m_stall < SC_MAX) ? m_stall + 1 : SC_MAX;
            if (m_wait) begin
                m_wcnt = (m_wcnt < TIMEOUT) ? m_wcnt + 1 : TIMEOUT;
                if (m_wcnt == TIMEOUT) m_err = 1;
            end else begin
                m_wcnt = 0;
            end
            m_wait = frz;
        end
    end

    task automatic clear_inputs();
        bus.IF_ID_Rs = 5'd0; bus.IF_ID_Rt = 5'd0;
        bus.ID_Branch = 1'b0; bus.ID_BranchTaken = 1'b0; bus.ID_Jump = 1'b0;
        bus.ID_EX_MemRead = 1'b0; bus.ID_EX_RegWrite = 1'b0; bus.ID_EX_Rd = 5'd0;
        bus.EX_MEM_MemRead = 1'b0; bus.EX_MEM_MemWrite = 1'b0; bus.EX_MEM_Rd = 5'd0;
        bus.mem_ready = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset for one cycle; leaves the bench at posedge+1 with rst low
    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        chk("reset_outputs", 32'(outv()), 32'(P_RESET));
        chk("reset_stall_cycles", 32'(bus.stall_cycles), 32'd0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        clear_inputs();
        tick();
        do_reset();

        // Load-use on r2 as Rs: one stall, counter 0 -> 1
        bus.ID_EX_MemRead = 1'b1; bus.ID_EX_RegWrite = 1'b1; bus.ID_EX_Rd = 5'd2; bus.IF_ID_Rs = 5'd2;
        @(negedge clk);
        chk("lu_outputs", 32'(outv()), 32'(P_STALL));
        chk("lu_sc_before", 32'(bus.stall_cycles), 32'd0);
        tick();
        clear_inputs();
        @(negedge clk);
        chk("lu_after", 32'(outv()), 32'(P_RUN));
        chk("lu_sc_after", 32'(bus.stall_cycles), 32'd1);
        tick();

        // r0 never matches
        bus.ID_EX_MemRead = 1'b1; bus.ID_EX_Rd = 5'd0; bus.IF_ID_Rs = 5'd0;
        @(negedge clk);
        chk("r0_no_stall", 32'(outv()), 32'(P_RUN));
        tick();

        // beq r3 with ALU producer in EX: one stall, then taken -> flush
        clear_inputs();
        bus.ID_Branch = 1'b1; bus.IF_ID_Rs = 5'd3; bus.ID_EX_RegWrite = 1'b1; bus.ID_EX_Rd = 5'd3;
        @(negedge clk);
        chk("br_alu_stall", 32'(outv()), 32'(P_STALL));
        tick();
        bus.ID_EX_RegWrite = 1'b0; bus.ID_EX_Rd = 5'd0; bus.EX_MEM_Rd = 5'd3; bus.ID_BranchTaken = 1'b1;
        @(negedge clk);
        chk("br_alu_redirect", 32'(outv()), 32'(P_REDIR));
        tick();

        // beq r3 with load producer: two stalls, then taken -> flush for one cycle
        clear_inputs();
        bus.ID_Branch = 1'b1; bus.IF_ID_Rt = 5'd3;
        bus.ID_EX_MemRead = 1'b1; bus.ID_EX_RegWrite = 1'b1; bus.ID_EX_Rd = 5'd3;
        @(negedge clk);
        chk("br_ld_stall1", 32'(outv()), 32'(P_STALL));
        tick();
        bus.ID_EX_MemRead = 1'b0; bus.ID_EX_RegWrite = 1'b0; bus.ID_EX_Rd = 5'd0;
        bus.EX_MEM_MemRead = 1'b1; bus.EX_MEM_Rd = 5'd3; bus.mem_ready = 1'b1;
        @(negedge clk);
        chk("br_ld_stall2", 32'(outv()), 32'(P_STALL));
        tick();
        bus.EX_MEM_MemRead = 1'b0; bus.EX_MEM_Rd = 5'd0; bus.ID_BranchTaken = 1'b1;
        @(negedge clk);
        chk("br_ld_redirect", 32'(outv()), 32'(P_REDIR));
        tick();
        clear_inputs();
        @(negedge clk);
        chk("br_ld_flush_once", 32'(bus.IF_ID_Flush), 32'd0);
        tick();

        // Store with 3 wait cycles, jump in ID must not flush
        do_reset();
        bus.EX_MEM_MemWrite = 1'b1; bus.mem_ready = 1'b0; bus.ID_Jump = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("st_freeze", 32'(outv()), 32'(P_FREEZE));
            tick();
        end
        bus.mem_ready = 1'b1;
        @(negedge clk);
        chk("st_release_redirect", 32'(outv()), 32'(P_REDIR));
        chk("st_sc", 32'(bus.stall_cycles), 32'd3);
        tick();
        clear_inputs();

        // Timeout: ready low 6 cycles, error after 4th MEM_WAIT edge, sticky
        do_reset();
        bus.EX_MEM_MemRead = 1'b1; bus.EX_MEM_Rd = 5'd7; bus.mem_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("to_err_progress", 32'(bus.mem_error), (i >= 5) ? 32'd1 : 32'd0);
            tick();
        end
        bus.mem_ready = 1'b1;
        tick();
        clear_inputs();
        @(negedge clk);
        chk("to_err_sticky", 32'(bus.mem_error), 32'd1);
        chk("to_run_after", 32'(outv()), 32'(P_RUN));
        tick();
        do_reset();
        @(negedge clk);
        chk("to_err_cleared", 32'(bus.mem_error), 32'd0);
        tick();

        // Saturation: 9 load-use stalls with CNT_W=3 -> 7
        do_reset();
        bus.ID_EX_MemRead = 1'b1; bus.ID_EX_Rd = 5'd9; bus.IF_ID_Rt = 5'd9;
        repeat (9) tick();
        clear_inputs();
        @(negedge clk);
        chk("sat_stall_cycles", 32'(bus.stall_cycles), 32'd7);
        tick();

        // Reset in the middle of MEM_WAIT
        bus.EX_MEM_MemWrite = 1'b1; bus.mem_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        @(negedge clk);
        chk("midwait_rst_outputs", 32'(outv()), 32'(P_RESET));
        chk("midwait_rst_sc", 32'(bus.stall_cycles), 32'd0);
        tick();
        rst = 1'b0;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        chk("midwait_run", 32'(outv()), 32'(P_RUN));
        chk("midwait_sc_hold", 32'(bus.stall_cycles), 32'd0);
        tick();

        // Randomized traffic checked by the model
        for (int i = 0; i < 1000; i++) begin
            rst                 = ($urandom_range(0, 149) == 0);
            bus.IF_ID_Rs        = 5'($urandom_range(0, 3));
            bus.IF_ID_Rt        = 5'($urandom_range(0, 3));
            bus.ID_Branch       = ($urandom_range(0, 3) == 0);
            bus.ID_BranchTaken  = 1'($urandom_range(0, 1));
            bus.ID_Jump         = ($urandom_range(0, 7) == 0);
            bus.ID_EX_MemRead   = ($urandom_range(0, 2) == 0);
            bus.ID_EX_RegWrite  = 1'($urandom_range(0, 1));
            bus.ID_EX_Rd        = 5'($urandom_range(0, 3));
            bus.EX_MEM_MemRead  = ($urandom_range(0, 2) == 0);
            bus.EX_MEM_MemWrite = ($urandom_range(0, 4) == 0);
            bus.EX_MEM_Rd       = 5'($urandom_range(0, 3));
            bus.mem_ready       = ($urandom_range(0, 3) != 0);
            tick();
        end
        rst = 1'b0;
        clear_inputs();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
